serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 101 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice (two half adders, carries ORed) is
// sequenced LSB first over WIDTH clocks; the result is published on completion.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             ha1_s, ha1_c, ha2_s, ha2_c, slice_c;
  logic [WIDTH-1:0] res_next;

  // Full-adder slice built from two half adders on the current LSBs.
  assign ha1_s    = a_sh[0] ^ b_sh[0];
  assign ha1_c    = a_sh[0] & b_sh[0];
  assign ha2_s    = ha1_s ^ carry;
  assign ha2_c    = ha1_s & carry;
  assign slice_c  = ha1_c | ha2_c;
  assign res_next = {ha2_s, res[WIDTH-1:1]};

  // NOTE: every register here uses non-blocking assignment so all state
  // advances together on the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all datapath registers are reset, not just control, so an
      // aborted operation leaves no stale operand or result bits behind.
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= slice_c;
          res   <= res_next;
          cnt   <= cnt + CNT_W'(1);
          // Publish on the edge that consumes the MSB so sum is valid in DONE.
          if (cnt == LAST_BIT) begin
            sum   <= res_next;
            cout  <= slice_c;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized scoreboard bench for serial_adder_ctrl: stimulus pushes expected
// results with their due cycle, a negedge monitor pops and compares.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W:0] res;
    int         acc;
  } exp_t;

  exp_t       sb[$];
  logic [W:0] last_res = '0;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic       prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: busy window, done timing, result value and result hold.
  always @(negedge clk) begin
    logic exp_busy;
    exp_busy = (sb.size() > 0) && (cyc >= sb[0].acc);
    check("busy", busy, exp_busy);
    check("done_not_twice", prev_done & done, 1'b0);
    prev_done = done;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.acc + W);
        check("result", {cout, sum}, e.res);
        last_res = e.res;
      end
    end else begin
      check("result_hold", {cout, sum}, last_res);
      if (sb.size() > 0 && cyc > sb[0].acc + W) check("missing_done", 1'b0, 1'b1);
    end
  end

  // Issue one operation, then scramble inputs for the whole busy window.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    e.res = {1'b0, x} + {1'b0, y};
    e.acc = cyc;
    sb.push_back(e);
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      start = hold ? 1'b1 : 1'($urandom);
      a = (i == 0) ? 8'h80 : W'($urandom);
      b = W'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, '0);
    check("rst_cout", cout, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(8'h0F, 8'h01, 1'b0); idle(1);
    issue(8'hFF, 8'h01, 1'b0); idle(2);
    issue(8'hFF, 8'hFF, 1'b0); idle(1);
    issue(8'h00, 8'h00, 1'b0); idle(3);

    // Start held high, operands changed during RUN, back-to-back acceptance.
    issue(8'h01, 8'h02, 1'b1);
    issue(8'h55, 8'hAA, 1'b1);
    issue(8'hC3, 8'h7E, 1'b1);
    idle(2);

    // Reset during the 4th RUN cycle aborts without a done pulse.
    @(negedge clk);
    start = 1'b1;
    a = 8'h9C;
    b = 8'h77;
    @(posedge clk);
    #1;
    e.res = {1'b0, a} + {1'b0, b};
    e.acc = cyc;
    sb.push_back(e);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    last_res = '0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, '0);
    check("abort_cout", cout, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h10, 8'h20, 1'b0); idle(1);

    for (int n = 0; n < 1000; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      idle($urandom_range(0, 2));
    end

    idle(1);
    for (int t = 0; t < 4 * W && sb.size() > 0; t++) @(negedge clk);
    check("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
